// File: rtl/cnn_frame_sched.sv
// Frame-level sequencer for the CNN display pipeline: shadows config, clears and
// runs the pipeline, counts output writes and swaps ping-pong banks at LCD VSync.
module cnn_frame_sched #(
   parameter int unsigned WIDTH   = 480,
   parameter int unsigned HEIGHT  = 272,
   parameter int unsigned DEPTH   = WIDTH * HEIGHT,
   parameter int unsigned CNT_W   = 17,
   parameter int unsigned CLR_CYC = 4,
   parameter int unsigned TIMEOUT = 262143
) (
   input  logic        iClk,
   input  logic        iRsn,
   input  logic        iEnClk,
   input  logic        iStart,
   input  logic        iCont,
   input  logic        iAbort,
   input  logic [31:0] iReg0,
   input  logic [31:0] iReg1,
   input  logic [31:0] iReg2,
   input  logic [31:0] iReg3,
   input  logic        iWrEn,
   input  logic        iLcdFrameStart,
   output logic [31:0] oCfg0,
   output logic [31:0] oCfg1,
   output logic [31:0] oCfg2,
   output logic [31:0] oCfg3,
   output logic        oPipeClr,
   output logic        oPipeRun,
   output logic        oWrBank,
   output logic        oRdBank,
   output logic        oBusy,
   output logic        oDone,
   output logic        oErr,
   output logic [15:0] oFrameCnt
);

   localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(DEPTH - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_RUN,
      S_SWAP
   } state_e;

   state_e             state_q, state_d;
   logic               start_q, start_d;
   logic [3:0][31:0]   cfg_q, cfg_d;
   logic               clr_q, clr_d;
   logic               run_q, run_d;
   logic               wr_bank_q, wr_bank_d;
   logic               rd_bank_q, rd_bank_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [15:0]        frame_q, frame_d;
   logic [CNT_W-1:0]   pix_q, pix_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [CLR_W-1:0]   clrc_q, clrc_d;
   logic               abort_pend_q, abort_pend_d;
   logic               start_edge;

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         state_q      <= S_IDLE;
         start_q      <= 1'b0;
         cfg_q        <= '0;
         clr_q        <= 1'b0;
         run_q        <= 1'b0;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         frame_q      <= '0;
         pix_q        <= '0;
         wd_q         <= '0;
         clrc_q       <= '0;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         cfg_q        <= cfg_d;
         clr_q        <= clr_d;
         run_q        <= run_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         done_q       <= done_d;
         err_q        <= err_d;
         frame_q      <= frame_d;
         pix_q        <= pix_d;
         wd_q         <= wd_d;
         clrc_q       <= clrc_d;
         abort_pend_q <= abort_pend_d;
      end
   end

   // Next-state logic; nothing moves unless the pixel-rate enable is high.
   always_comb begin
      state_d      = state_q;
      start_d      = start_q;
      cfg_d        = cfg_q;
      clr_d        = clr_q;
      run_d        = run_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      done_d       = done_q;
      err_d        = err_q;
      frame_d      = frame_q;
      pix_d        = pix_q;
      wd_d         = wd_q;
      clrc_d       = clrc_q;
      abort_pend_d = abort_pend_q;
      start_edge   = iStart & ~start_q;

      if (iEnClk) begin
         start_d = iStart;
         unique case (state_q)
            S_IDLE: begin
               if (start_edge) begin
                  done_d       = 1'b0;
                  err_d        = 1'b0;
                  abort_pend_d = 1'b0;
                  state_d      = S_LOAD;
               end
            end
            S_LOAD: begin
               if (iAbort) begin
                  err_d   = 1'b1;
                  clr_d   = 1'b0;
                  run_d   = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  cfg_d   = {iReg3, iReg2, iReg1, iReg0};
                  clr_d   = 1'b1;
                  clrc_d  = '0;
                  state_d = S_CLEAR;
               end
            end
            S_CLEAR: begin
               pix_d = '0;
               wd_d  = '0;
               if (iAbort) begin
                  err_d   = 1'b1;
                  clr_d   = 1'b0;
                  run_d   = 1'b0;
                  state_d = S_IDLE;
               end else if (clrc_q == CLR_LAST) begin
                  clr_d   = 1'b0;
                  run_d   = 1'b1;
                  state_d = S_RUN;
               end else begin
                  clrc_d = clrc_q + CLR_W'(1);
               end
            end
            S_RUN: begin
               // Priority: abort, then frame completion, then watchdog.
               if (iAbort) begin
                  err_d   = 1'b1;
                  clr_d   = 1'b0;
                  run_d   = 1'b0;
                  state_d = S_IDLE;
               end else if (iWrEn && (pix_q == LAST_PIX)) begin
                  pix_d   = pix_q + CNT_W'(1);
                  run_d   = 1'b0;
                  state_d = S_SWAP;
               end else begin
                  if (iWrEn) begin
                     pix_d = pix_q + CNT_W'(1);
                  end
                  wd_d = wd_q + WD_W'(1);
                  if (wd_q == WD_LAST) begin
                     err_d   = 1'b1;
                     run_d   = 1'b0;
                     state_d = S_IDLE;
                  end
               end
            end
            S_SWAP: begin
               // Abort is held off until the bank swap has happened.
               if (iLcdFrameStart) begin
                  wr_bank_d    = ~wr_bank_q;
                  rd_bank_d    = ~rd_bank_q;
                  done_d       = 1'b1;
                  frame_d      = frame_q + 16'd1;
                  abort_pend_d = 1'b0;
                  if (iAbort || abort_pend_q) begin
                     err_d   = 1'b1;
                     state_d = S_IDLE;
                  end else if (iCont) begin
                     state_d = S_LOAD;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else if (iAbort) begin
                  abort_pend_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign oCfg0     = cfg_q[0];
   assign oCfg1     = cfg_q[1];
   assign oCfg2     = cfg_q[2];
   assign oCfg3     = cfg_q[3];
   assign oPipeClr  = clr_q;
   assign oPipeRun  = run_q;
   assign oWrBank   = wr_bank_q;
   assign oRdBank   = rd_bank_q;
   assign oBusy     = (state_q != S_IDLE);
   assign oDone     = done_q;
   assign oErr      = err_q;
   assign oFrameCnt = frame_q;

endmodule
